// File: rtl/dpram_acq_controller.sv
// Write-side sequencer for a circular acquisition buffer: arm, pre-trigger fill,
// wait for trigger, post-trigger capture, then freeze the window for read-out.
module dpram_acq_controller #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trigger,
    input  logic                     sampleValid,
    input  logic [DATA_WIDTH-1:0]    sampleData,
    input  logic [ADDRESS_WIDTH-1:0] preTriggerCount,
    input  logic [ADDRESS_WIDTH-1:0] postTriggerCount,
    output logic                     wEnable,
    output logic [ADDRESS_WIDTH-1:0] wAddr,
    output logic [DATA_WIDTH-1:0]    wData,
    output logic                     busy,
    output logic                     done,
    output logic                     configError,
    output logic [ADDRESS_WIDTH-1:0] triggerAddr,
    output logic [ADDRESS_WIDTH-1:0] startAddr
);

    localparam logic [ADDRESS_WIDTH-1:0] ONE   = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0]   DEPTH = (ADDRESS_WIDTH+1)'(1) << ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] next_addr_reg, next_addr_next;
    logic [ADDRESS_WIDTH-1:0] count_reg, count_next;
    logic [ADDRESS_WIDTH-1:0] pre_reg, pre_next;
    logic [ADDRESS_WIDTH-1:0] post_reg, post_next;
    logic                     trig_pending_reg, trig_pending_next;
    logic                     config_error_next;
    logic [ADDRESS_WIDTH-1:0] trigger_addr_next;
    logic [ADDRESS_WIDTH-1:0] start_addr_next;
    logic                     write_en;
    logic [ADDRESS_WIDTH:0]   window_size;
    logic                     window_too_big;

    // Window = pre + trigger sample + post; one extra bit so the sum cannot wrap.
    assign window_size    = {1'b0, preTriggerCount} + {1'b0, postTriggerCount} + (ADDRESS_WIDTH+1)'(1);
    assign window_too_big = window_size > DEPTH;

    always_comb begin
        state_next        = state_reg;
        next_addr_next    = next_addr_reg;
        count_next        = count_reg;
        pre_next          = pre_reg;
        post_next         = post_reg;
        trig_pending_next = trig_pending_reg;
        config_error_next = configError;
        trigger_addr_next = triggerAddr;
        start_addr_next   = startAddr;
        write_en          = 1'b0;

        if (abort) begin
            state_next        = S_IDLE;
            trig_pending_next = 1'b0;
        end else begin
            unique case (state_reg)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        if (window_too_big) begin
                            config_error_next = 1'b1;
                            state_next        = S_IDLE;
                        end else begin
                            config_error_next = 1'b0;
                            pre_next          = preTriggerCount;
                            post_next         = postTriggerCount;
                            next_addr_next    = '0;
                            count_next        = '0;
                            trig_pending_next = 1'b0;
                            state_next        = (preTriggerCount == '0) ? S_ARMED : S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (sampleValid) begin
                        write_en   = 1'b1;
                        count_next = count_reg + ONE;
                        if (count_reg + ONE == pre_reg) begin
                            count_next = '0;
                            state_next = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (sampleValid) begin
                        write_en = 1'b1;
                        if (trigger || trig_pending_reg) begin
                            trigger_addr_next = next_addr_reg;
                            start_addr_next   = next_addr_reg - pre_reg;
                            trig_pending_next = 1'b0;
                            count_next        = '0;
                            state_next        = (post_reg == '0) ? S_DONE : S_POST;
                        end
                    end else if (trigger) begin
                        // Remember a trigger that landed on an idle sample slot.
                        trig_pending_next = 1'b1;
                    end
                end
                S_POST: begin
                    if (sampleValid) begin
                        write_en   = 1'b1;
                        count_next = count_reg + ONE;
                        if (count_reg + ONE == post_reg) begin
                            state_next = S_DONE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        if (write_en) begin
            next_addr_next = next_addr_reg + ONE;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg        <= S_IDLE;
            next_addr_reg    <= '0;
            count_reg        <= '0;
            pre_reg          <= '0;
            post_reg         <= '0;
            trig_pending_reg <= 1'b0;
            wEnable          <= 1'b0;
            wAddr            <= '0;
            wData            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            configError      <= 1'b0;
            triggerAddr      <= '0;
            startAddr        <= '0;
        end else begin
            state_reg        <= state_next;
            next_addr_reg    <= next_addr_next;
            count_reg        <= count_next;
            pre_reg          <= pre_next;
            post_reg         <= post_next;
            trig_pending_reg <= trig_pending_next;
            wEnable          <= write_en;
            if (write_en) begin
                wAddr <= next_addr_reg;
                wData <= sampleData;
            end
            // Status follows the state being entered so it lines up with the write it reflects.
            busy        <= (state_next == S_PRE) || (state_next == S_ARMED) || (state_next == S_POST);
            done        <= (state_next == S_DONE);
            configError <= config_error_next;
            triggerAddr <= trigger_addr_next;
            startAddr   <= start_addr_next;
        end
    end

endmodule

// File: tb/tb_dpram_acq_controller.sv
// Randomised and directed bench for dpram_acq_controller with a transaction-level
// model of which samples land where and where the captured window starts.
module tb_dpram_acq_controller;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int MAXC  = 512;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trigger = 1'b0;
    logic          sampleValid = 1'b0;
    logic [DW-1:0] sampleData = '0;
    logic [AW-1:0] preTriggerCount = '0;
    logic [AW-1:0] postTriggerCount = '0;
    logic          wEnable;
    logic [AW-1:0] wAddr;
    logic [DW-1:0] wData;
    logic          busy;
    logic          done;
    logic          configError;
    logic [AW-1:0] triggerAddr;
    logic [AW-1:0] startAddr;

    dpram_acq_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstN(rstN), .arm(arm), .abort(abort), .trigger(trigger),
        .sampleValid(sampleValid), .sampleData(sampleData),
        .preTriggerCount(preTriggerCount), .postTriggerCount(postTriggerCount),
        .wEnable(wEnable), .wAddr(wAddr), .wData(wData), .busy(busy), .done(done),
        .configError(configError), .triggerAddr(triggerAddr), .startAddr(startAddr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-cycle stimulus tables, indexed from the first cycle after arm.
    logic          valid_a [MAXC];
    logic          trig_a  [MAXC];
    logic          arm_a   [MAXC];
    logic [DW-1:0] data_a  [MAXC];

    // Writes seen on the DPRAM port and the status presented alongside each.
    int            obs_addr [$];
    logic [DW-1:0] obs_data [$];
    logic          obs_done [$];
    logic          obs_busy [$];
    int            obs_cyc  [$];

    // Model results.
    int            exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int            exp_tidx;
    bit            exp_complete;

    task automatic clear_stim(input int valid_pct);
        for (int c = 0; c < MAXC; c++) begin
            valid_a[c] = ($urandom_range(99, 0) < valid_pct);
            trig_a[c]  = 1'b0;
            arm_a[c]   = 1'b0;
            data_a[c]  = DW'($urandom);
        end
    endtask

    // The i-th valid sample after an accepted arm lands at address i mod depth.
    // The trigger counts only once pre samples have been written; it selects the
    // first valid sample at or after it, and capture stops post samples later.
    task automatic model(input int pre, input int post, input int n);
        int  vc;
        bit  seen;
        vc = 0;
        seen = 0;
        exp_tidx = -1;
        exp_addr.delete();
        exp_data.delete();
        for (int c = 0; c < n; c++) begin
            if (exp_tidx >= 0 && vc == exp_tidx + 1 + post) break;
            if (trig_a[c] && vc >= pre && exp_tidx < 0) seen = 1;
            if (valid_a[c]) begin
                exp_addr.push_back(vc % DEPTH);
                exp_data.push_back(data_a[c]);
                if (seen && exp_tidx < 0) exp_tidx = vc;
                vc++;
            end
        end
        exp_complete = (exp_tidx >= 0) && (vc == exp_tidx + 1 + post);
    endtask

    task automatic do_arm(input int pre, input int post);
        preTriggerCount  = AW'(pre);
        postTriggerCount = AW'(post);
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic run_stream(input int n, input int tail);
        obs_addr.delete(); obs_data.delete(); obs_done.delete(); obs_busy.delete(); obs_cyc.delete();
        for (int c = 0; c < n + tail; c++) begin
            sampleValid = (c < n) ? valid_a[c] : 1'b0;
            trigger     = (c < n) ? trig_a[c]  : 1'b0;
            arm         = (c < n) ? arm_a[c]   : 1'b0;
            sampleData  = (c < n) ? data_a[c]  : '0;
            @(posedge clk); #1;
            if (wEnable) begin
                obs_addr.push_back(int'(wAddr));
                obs_data.push_back(wData);
                obs_done.push_back(done);
                obs_busy.push_back(busy);
                obs_cyc.push_back(c);
            end
        end
        sampleValid = 1'b0; trigger = 1'b0; arm = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({wEnable, wAddr, wData, busy, done, configError, triggerAddr, startAddr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b addr=%0h data=%0h busy=%0b done=%0b cerr=%0b trig=%0h start=%0h required all 0",
                     wEnable, wAddr, wData, busy, done, configError, triggerAddr, startAddr);
        end
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || wEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b we=%0b required 0 0", busy, wEnable);
        end
    endtask

    task automatic test_basic();
        clear_stim(100);
        trig_a[40] = 1'b1;
        model(10, 20, 100);
        do_arm(10, 20);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_arm: got %0b required 1", busy); end
        run_stream(100, 4);
        checks++;
        if (obs_addr.size() != 61 || exp_addr.size() != 61) begin
            errors++; $display("FAIL basic_write_count: got %0d required 61", obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != i) begin
                errors++;
                $display("FAIL basic_write[%0d]: got addr=%0d data=%0h cyc=%0d required addr=%0d data=%0h cyc=%0d",
                         i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], i);
            end
        end
        checks++;
        if (triggerAddr !== 7'd40 || startAddr !== 7'd30) begin
            errors++; $display("FAIL basic_window: got trig=%0d start=%0d required 40 30", triggerAddr, startAddr);
        end
        if (obs_addr.size() >= 2) begin
            checks++;
            if (obs_done[$] !== 1'b1 || obs_busy[$] !== 1'b0 || obs_done[$-1] !== 1'b0 || obs_busy[$-1] !== 1'b1) begin
                errors++;
                $display("FAIL basic_done_timing: got last done/busy=%0b/%0b prev=%0b/%0b required 1/0 0/1",
                         obs_done[$], obs_busy[$], obs_done[$-1], obs_busy[$-1]);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_hold: got done=%0b busy=%0b required 1 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        clear_stim(100);
        trig_a[200] = 1'b1;
        model(10, 20, 240);
        do_arm(10, 20);
        run_stream(240, 3);
        checks++;
        if (obs_addr.size() != exp_addr.size() || obs_addr.size() == 0) begin
            errors++; $display("FAIL wrap_write_count: got %0d required %0d", obs_addr.size(), exp_addr.size());
        end else if (obs_addr[$] != 92) begin
            errors++; $display("FAIL wrap_last_addr: got %0d required 92", obs_addr[$]);
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL wrap_write[%0d]: got addr=%0d data=%0h required addr=%0d data=%0h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (triggerAddr !== 7'd72 || startAddr !== 7'd62 || done !== 1'b1) begin
            errors++; $display("FAIL wrap_window: got trig=%0d start=%0d done=%0b required 72 62 1", triggerAddr, startAddr, done);
        end
    endtask

    task automatic test_pretrigger();
        clear_stim(100);
        trig_a[5]   = 1'b1;
        valid_a[16] = 1'b0;
        trig_a[16]  = 1'b1;
        model(10, 20, 60);
        do_arm(10, 20);
        run_stream(60, 3);
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL pretrig_write_count: got %0d required %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL pretrig_write[%0d]: got addr=%0d data=%0h required addr=%0d data=%0h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (triggerAddr !== 7'd16 || startAddr !== 7'd6 || done !== 1'b1) begin
            errors++; $display("FAIL pretrig_window: got trig=%0d start=%0d done=%0b required 16 6 1", triggerAddr, startAddr, done);
        end
    endtask

    task automatic test_config();
        do_abort();
        do_arm(100, 28);
        checks++;
        if (configError !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL cfg_reject: got cerr=%0b busy=%0b done=%0b required 1 0 0", configError, busy, done);
        end
        clear_stim(100);
        trig_a[3] = 1'b1;
        run_stream(20, 1);
        checks++;
        if (obs_addr.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL cfg_reject_no_writes: got %0d writes busy=%0b required 0 0", obs_addr.size(), busy);
        end
        do_arm(100, 27);
        checks++;
        if (configError !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL cfg_full_window: got cerr=%0b busy=%0b required 0 1", configError, busy);
        end
        do_abort();
        clear_stim(100);
        trig_a[3] = 1'b1;
        model(0, 0, 10);
        do_arm(0, 0);
        run_stream(10, 2);
        checks++;
        if (obs_addr.size() != exp_addr.size() || obs_addr.size() != 4) begin
            errors++; $display("FAIL cfg_zero_count: got %0d writes required 4", obs_addr.size());
        end else begin
            checks++;
            if (obs_addr[3] != 3 || obs_data[3] !== exp_data[3] || obs_done[3] !== 1'b1 || obs_busy[3] !== 1'b0) begin
                errors++;
                $display("FAIL cfg_zero_trigger_write: got addr=%0d data=%0h done=%0b busy=%0b required 3 %0h 1 0",
                         obs_addr[3], obs_data[3], obs_done[3], obs_busy[3], exp_data[3]);
            end
        end
        checks++;
        if (triggerAddr !== 7'd3 || startAddr !== 7'd3 || done !== 1'b1) begin
            errors++; $display("FAIL cfg_zero_window: got trig=%0d start=%0d done=%0b required 3 3 1", triggerAddr, startAddr, done);
        end
    endtask

    task automatic test_abort();
        do_abort();
        preTriggerCount = 7'd5; postTriggerCount = 7'd5;
        arm = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_arm_same_cycle: got busy=%0b done=%0b required 0 0", busy, done);
        end
        clear_stim(100);
        trig_a[4] = 1'b1;
        do_arm(2, 50);
        run_stream(20, 0);
        sampleValid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (wEnable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_in_post: got we=%0b busy=%0b done=%0b required 0 0 0", wEnable, busy, done);
        end
        checks++;
        if (triggerAddr !== 7'd4 || startAddr !== 7'd2) begin
            errors++; $display("FAIL abort_keeps_window: got trig=%0d start=%0d required 4 2", triggerAddr, startAddr);
        end
        @(posedge clk); #1;
        sampleValid = 1'b0;
        checks++;
        if (wEnable !== 1'b0) begin
            errors++; $display("FAIL abort_stays_idle: got we=%0b required 0", wEnable);
        end
    endtask

    task automatic test_arm_while_busy();
        do_abort();
        clear_stim(100);
        trig_a[30] = 1'b1;
        arm_a[2]   = 1'b1;
        arm_a[20]  = 1'b1;
        model(5, 5, 60);
        do_arm(5, 5);
        preTriggerCount = 7'd50; postTriggerCount = 7'd50;
        run_stream(60, 2);
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL armbusy_write_count: got %0d required %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL armbusy_write[%0d]: got addr=%0d required %0d", i, obs_addr[i], exp_addr[i]);
            end
        end
        checks++;
        if (triggerAddr !== 7'd30 || startAddr !== 7'd25 || done !== 1'b1) begin
            errors++; $display("FAIL armbusy_window: got trig=%0d start=%0d done=%0b required 30 25 1", triggerAddr, startAddr, done);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int pre, post;
            pre  = $urandom_range(40, 0);
            post = $urandom_range(40, 0);
            do_abort();
            clear_stim(75);
            for (int c = 0; c < 300; c++) trig_a[c] = ($urandom_range(99, 0) < 4);
            model(pre, post, 300);
            do_arm(pre, post);
            run_stream(300, 2);
            checks++;
            if (obs_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL rand%0d_write_count: got %0d required %0d", t, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write[%0d]: got addr=%0d data=%0h required addr=%0d data=%0h",
                             t, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
            checks++;
            if (exp_complete) begin
                if (done !== 1'b1 || busy !== 1'b0 || triggerAddr !== AW'(exp_tidx) || startAddr !== AW'(exp_tidx - pre)) begin
                    errors++;
                    $display("FAIL rand%0d_window: got done=%0b trig=%0d start=%0d required 1 %0d %0d",
                             t, done, triggerAddr, startAddr, exp_tidx % DEPTH, (exp_tidx - pre + DEPTH) % DEPTH);
                end
            end else if (done !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL rand%0d_incomplete: got done=%0b busy=%0b required 0 1", t, done, busy);
            end
            $display("rand%0d pre=%0d post=%0d writes=%0d tidx=%0d complete=%0b", t, pre, post, obs_addr.size(), exp_tidx, exp_complete);
        end
    endtask

    task automatic test_reset_mid_capture();
        do_abort();
        clear_stim(100);
        trig_a[12] = 1'b1;
        do_arm(10, 20);
        run_stream(25, 0);
        sampleValid = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b1 || wEnable !== 1'b1) begin
            errors++; $display("FAIL rstmid_precondition: got busy=%0b we=%0b required 1 1", busy, wEnable);
        end
        rstN = 1'b0;
        #1;
        checks++;
        if ({wEnable, wAddr, wData, busy, done, configError, triggerAddr, startAddr} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got we=%0b addr=%0h data=%0h busy=%0b trig=%0h start=%0h required all 0",
                     wEnable, wAddr, wData, busy, triggerAddr, startAddr);
        end
        sampleValid = 1'b0;
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        test_reset();
        $display("test_reset done");
        test_basic();
        $display("test_basic done");
        test_wrap();
        $display("test_wrap done");
        test_pretrigger();
        $display("test_pretrigger done");
        test_config();
        $display("test_config done");
        test_abort();
        $display("test_abort done");
        test_arm_while_busy();
        $display("test_arm_while_busy done");
        test_random();
        test_reset_mid_capture();
        $display("test_reset_mid_capture done");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
